neuron_mac_sequencer: RTL and testbench
=======================================

NEURON_MAC_SEQUENCER -- requirements
Module: neuron_mac_sequencer

Interface
REQ-001 Parameter BITS, 32, signed fixed-point word width with BITS/2 fraction bits.
REQ-002 Parameter N_INPUTS, 8, number of input/weight pairs per neuron evaluation (legal range 2..256).
REQ-003 Localparam ADDR_W, max(1,$clog2(N_INPUTS)), rd_addr width.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  request a neuron evaluation; sampled only in IDLE.
REQ-007 bias  in  BITS  signed bias, captured on the start-accept edge.
REQ-008 relu_en  in  1  activation select, captured on the start-accept edge.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 rd_en  out  1  operand memory read strobe.
REQ-011 rd_addr  out  ADDR_W  index of input/weight pair being read.
REQ-012 x_data  in  BITS  input activation, valid the cycle after rd_en.
REQ-013 w_data  in  BITS  weight, valid the cycle after rd_en.
REQ-014 out_data  out  BITS  neuron result, stable while out_valid high.
REQ-015 out_valid  out  1  result valid; held until out_ready.
REQ-016 out_ready  in  1  consumer accepts result when high with out_valid.
REQ-017 sat_flag  out  1  at least one accumulator saturation occurred in the current/last run.

Function
REQ-018 States SHALL be IDLE, ISSUE, DRAIN, DONE.
REQ-019 IDLE: start=1 SHALL move to ISSUE, set acc=bias, idx=0, clear sat_flag, latch relu_en.
REQ-020 ISSUE: rd_en=1, rd_addr=idx each cycle; idx increments; after N_INPUTS cycles (idx=N_INPUTS-1 issued) move to DRAIN.
REQ-021 Product of x_data*w_data SHALL come from the signed Q(BITS/2) multiplier, registered on the edge ending the data cycle (rd_en cycle +1).
REQ-022 Registered product SHALL be added to acc one edge later (rd_en cycle +2); pipeline valid bit tracks each product.
REQ-023 Accumulation SHALL saturate: positive overflow -> 2^(BITS-1)-1, negative overflow -> -2^(BITS-1); any saturation sets sat_flag (sticky until next start).
REQ-024 DRAIN SHALL last exactly 2 cycles, then enter DONE with out_valid=1.
REQ-025 Latency: out_valid first high N_INPUTS+2 cycles after the start-accept edge.
REQ-026 out_data SHALL equal final acc, or 0 if latched relu_en=1 and acc negative.
REQ-027 DONE: out_valid held, out_data stable until out_valid&out_ready; then IDLE same edge.
REQ-028 start outside IDLE SHALL be ignored (no queueing); earliest new accept is the cycle after leaving DONE.
REQ-029 bias/relu_en changes after the accept edge SHALL not affect the run.
REQ-030 rd_en SHALL be 0 in IDLE, DRAIN, DONE.

Reset
REQ-031 rst=1 SHALL force IDLE, acc=0, idx=0, pipeline valid bits 0, busy=0, rd_en=0, rd_addr=0, out_valid=0, out_data=0, sat_flag=0.
REQ-032 rst mid-run SHALL abort immediately; in-flight products discarded; no out_valid produced.
REQ-033 rst has priority over start and out_ready in the same cycle.

Structure
REQ-034 State enum, saturation limits (MAX_POS, MAX_NEG) SHALL live in shared package nn_pkg.
REQ-035 One sub-module: the existing Multiplier #(BITS), instantiated once, fed combinationally by x_data/w_data.
REQ-036 Saturating adder SHALL be a function in nn_pkg, not a separate module.

Verification
REQ-037 N=4, bias=0x0001_0000, x={1.0,2.0,0.5,-1.0}, w={0.5,0.25,2.0,1.0} -> out_data=0x0002_0000, out_valid at accept+6 cycles, sat_flag=0.
REQ-038 N=4, all x=w=0x7F00_0000 -> out_data=0x7FFF_FFFF, sat_flag=1; repeat with x negated -> 0x8000_0000, sat_flag=1.
REQ-039 relu_en=1, bias=-2.0, all products 0 -> out_data=0; relu_en=0 same -> 0xFFFE_0000.
REQ-040 out_ready low 5 cycles in DONE -> out_valid and out_data stable all 5; start pulses during run/DONE ignored.
REQ-041 rst asserted during ISSUE idx=2 -> next cycle IDLE, all outputs 0; fresh start gives correct result.
REQ-042 Back-to-back: out_ready=1 and start=1 continuously -> accepts spaced N_INPUTS+4 cycles, rd_addr sequence 0..N-1 each run.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the neuron MAC sequencer.
//   state_t   : sequencer states
//   DATA_BITS : datapath word width, signed fixed point with DATA_BITS/2 fraction bits
//   MAX_POS / MAX_NEG : accumulator saturation limits
//   sat_add() : saturating signed add, reports whether it clipped
package nn_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int DATA_BITS = 32;

   localparam logic signed [DATA_BITS-1:0] MAX_POS = {1'b0, {(DATA_BITS-1){1'b1}}};
   localparam logic signed [DATA_BITS-1:0] MAX_NEG = {1'b1, {(DATA_BITS-1){1'b0}}};

   typedef struct packed {
      logic signed [DATA_BITS-1:0] sum;
      logic                        sat;
   } sat_sum_t;

   function automatic sat_sum_t sat_add(input logic signed [DATA_BITS-1:0] a,
                                        input logic signed [DATA_BITS-1:0] b);
      sat_sum_t                r;
      logic signed [DATA_BITS:0] s;
      s = {a[DATA_BITS-1], a} + {b[DATA_BITS-1], b};
      // The extra sign bit disagrees with the word's sign bit only on overflow.
      r.sat = (s[DATA_BITS] != s[DATA_BITS-1]);
      if (!r.sat) begin
         r.sum = s[DATA_BITS-1:0];
      end else if (s[DATA_BITS]) begin
         r.sum = MAX_NEG;
      end else begin
         r.sum = MAX_POS;
      end
      return r;
   endfunction

endpackage

// File: rtl/Multiplier.sv
// Combinational signed fixed-point multiplier, Q(BITS/2) in and out.
//   a_i, b_i : signed operands
//   p_o      : product, fraction bits truncated toward -inf, clipped to the
//              representable range when the integer part overflows
module Multiplier #(
   parameter int BITS = 32
) (
   input  logic signed [BITS-1:0] a_i,
   input  logic signed [BITS-1:0] b_i,
   output logic signed [BITS-1:0] p_o
);

   localparam logic signed [BITS-1:0] P_MAX = {1'b0, {(BITS-1){1'b1}}};
   localparam logic signed [BITS-1:0] P_MIN = {1'b1, {(BITS-1){1'b0}}};

   logic signed [2*BITS-1:0] full;
   logic signed [2*BITS-1:0] shifted;

   assign full    = a_i * b_i;
   assign shifted = full >>> (BITS/2);

   // Result fits when every bit above the output sign bit matches it.
   always_comb begin
      p_o = shifted[BITS-1:0];
      if ((shifted[2*BITS-1:BITS-1] != '0) && (shifted[2*BITS-1:BITS-1] != '1)) begin
         p_o = shifted[2*BITS-1] ? P_MIN : P_MAX;
      end
   end

endmodule

// File: rtl/neuron_mac_sequencer.sv
// Single-neuron multiply-accumulate sequencer.
// Reads N_INPUTS input/weight pairs, accumulates their products onto a bias
// with saturation, optionally applies ReLU and holds the result until taken.
//   clk, rst              : clock, synchronous active-high reset
//   start, bias, relu_en  : run request and its per-run settings
//   busy                  : high outside IDLE
//   rd_en, rd_addr        : operand read strobe and pair index
//   x_data, w_data        : operands, valid the cycle after rd_en
//   out_data, out_valid, out_ready : result handshake
//   sat_flag              : accumulator clipped during the current/last run
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | one operand read per cycle, rd_addr 0..N_INPUTS-1
// DRAIN | two cycles letting the last products reach the accumulator
// DONE  | result presented until out_ready
module neuron_mac_sequencer
   import nn_pkg::*;
#(
   parameter int BITS     = DATA_BITS,
   parameter int N_INPUTS = 8
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    start,
   input  logic signed [BITS-1:0]                  bias,
   input  logic                                    relu_en,
   output logic                                    busy,
   output logic                                    rd_en,
   output logic [((N_INPUTS > 1) ? $clog2(N_INPUTS) : 1)-1:0] rd_addr,
   input  logic signed [BITS-1:0]                  x_data,
   input  logic signed [BITS-1:0]                  w_data,
   output logic signed [BITS-1:0]                  out_data,
   output logic                                    out_valid,
   input  logic                                    out_ready,
   output logic                                    sat_flag
);

   localparam int ADDR_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_INPUTS - 1);

   state_t                  state_q, state_d;
   logic [ADDR_W-1:0]       idx_q, idx_d;
   logic                    drain_q, drain_d;
   logic                    accept;

   logic                    dvalid_q;
   logic                    pvalid_q;
   logic signed [BITS-1:0]  prod_w, prod_q;
   logic signed [BITS-1:0]  acc_q;
   logic                    sat_q;
   logic                    relu_q;
   sat_sum_t                acc_sum;

   Multiplier #(.BITS(BITS)) u_mult (
      .a_i (x_data),
      .b_i (w_data),
      .p_o (prod_w)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      drain_d   = drain_q;
      accept    = 1'b0;
      rd_en     = 1'b0;
      out_valid = 1'b0;
      busy      = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               idx_d   = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            rd_en = 1'b1;
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               drain_d = 1'b1;
               state_d = DRAIN;
            end else begin
               idx_d = idx_q + ADDR_W'(1);
            end
         end
         DRAIN: begin
            if (drain_q == 1'b0) begin
               state_d = DONE;
            end else begin
               drain_d = drain_q - 1'b1;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign acc_sum = sat_add(acc_q, prod_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         drain_q  <= 1'b0;
         dvalid_q <= 1'b0;
         pvalid_q <= 1'b0;
         prod_q   <= '0;
         acc_q    <= '0;
         sat_q    <= 1'b0;
         relu_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         drain_q  <= drain_d;
         // Operands arrive the cycle after rd_en; product lands one edge later.
         dvalid_q <= rd_en;
         pvalid_q <= dvalid_q;
         prod_q   <= prod_w;
         if (accept) begin
            acc_q  <= bias;
            sat_q  <= 1'b0;
            relu_q <= relu_en;
         end else if (pvalid_q) begin
            acc_q <= acc_sum.sum;
            sat_q <= sat_q | acc_sum.sat;
         end
      end
   end

   assign rd_addr  = idx_q;
   assign sat_flag = sat_q;
   assign out_data = (state_q != DONE)         ? '0 :
                     (relu_q && acc_q[BITS-1]) ? '0 : acc_q;

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
module tb_neuron_mac_sequencer;

   localparam int N  = 4;
   localparam int AW = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        relu_en = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] bias = '0;
   logic [31:0] x_data = '0;
   logic [31:0] w_data = '0;
   logic        busy, rd_en, out_valid, sat_flag;
   logic [AW-1:0] rd_addr;
   logic [31:0] out_data;

   logic [31:0] xm [N];
   logic [31:0] wm [N];

   int pass_cnt  = 0;
   int total_cnt = 0;

   neuron_mac_sequencer #(.BITS(32), .N_INPUTS(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .bias      (bias),
      .relu_en   (relu_en),
      .busy      (busy),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .x_data    (x_data),
      .w_data    (w_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sat_flag  (sat_flag)
   );

   always #5 clk = ~clk;

   // Operand memory: one-cycle read latency.
   always @(posedge clk) begin
      if (rd_en) begin
         x_data <= xm[rd_addr];
         w_data <= wm[rd_addr];
      end
   end

   task automatic set_mem(input logic [31:0] x0, x1, x2, x3, w0, w1, w2, w3);
      xm[0] = x0; xm[1] = x1; xm[2] = x2; xm[3] = x3;
      wm[0] = w0; wm[1] = w1; wm[2] = w2; wm[3] = w3;
   endtask

   // Accept a run, scramble bias/relu_en right after, wait for out_valid.
   // lat counts edges after the accept edge; 0 at the first negedge after it.
   task automatic run_to_done(input logic [31:0] b, input logic r, output int lat);
      @(negedge clk); start = 1'b1; bias = b; relu_en = r;
      @(negedge clk); start = 1'b0; bias = 32'hDEAD_BEEF; relu_en = ~r;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else pass_cnt++;
      total_cnt++; if (rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b exp 0", rd_en); else pass_cnt++;
      total_cnt++; if (rd_addr !== 2'd0) $display("FAIL reset_rd_addr: got %0d exp 0", rd_addr); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b exp 0", out_valid); else pass_cnt++;
      total_cnt++; if (out_data !== 32'h0) $display("FAIL reset_out_data: got %h exp 0", out_data); else pass_cnt++;
      total_cnt++; if (sat_flag !== 1'b0) $display("FAIL reset_sat_flag: got %b exp 0", sat_flag); else pass_cnt++;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int lat;
      set_mem(32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 32'hFFFF_0000,
              32'h0000_8000, 32'h0000_4000, 32'h0002_0000, 32'h0001_0000);
      run_to_done(32'h0001_0000, 1'b0, lat);
      total_cnt++; if (lat !== 6) $display("FAIL basic_latency: got %0d exp 6", lat); else pass_cnt++;
      total_cnt++; if (out_data !== 32'h0002_0000) $display("FAIL basic_out: got %h exp 00020000", out_data); else pass_cnt++;
      total_cnt++; if (sat_flag !== 1'b0) $display("FAIL basic_sat: got %b exp 0", sat_flag); else pass_cnt++;
      total_cnt++; if (busy !== 1'b1) $display("FAIL basic_busy_done: got %b exp 1", busy); else pass_cnt++;
      release_result();
      total_cnt++; if (busy !== 1'b0) $display("FAIL basic_idle_busy: got %b exp 0", busy); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_idle_valid: got %b exp 0", out_valid); else pass_cnt++;
   endtask

   task automatic test_saturation();
      int lat;
      set_mem(32'h7F00_0000, 32'h7F00_0000, 32'h7F00_0000, 32'h7F00_0000,
              32'h7F00_0000, 32'h7F00_0000, 32'h7F00_0000, 32'h7F00_0000);
      run_to_done(32'h0, 1'b0, lat);
      total_cnt++; if (out_data !== 32'h7FFF_FFFF) $display("FAIL sat_pos_out: got %h exp 7fffffff", out_data); else pass_cnt++;
      total_cnt++; if (sat_flag !== 1'b1) $display("FAIL sat_pos_flag: got %b exp 1", sat_flag); else pass_cnt++;
      release_result();
      set_mem(32'h8100_0000, 32'h8100_0000, 32'h8100_0000, 32'h8100_0000,
              32'h7F00_0000, 32'h7F00_0000, 32'h7F00_0000, 32'h7F00_0000);
      run_to_done(32'h0, 1'b0, lat);
      total_cnt++; if (out_data !== 32'h8000_0000) $display("FAIL sat_neg_out: got %h exp 80000000", out_data); else pass_cnt++;
      total_cnt++; if (sat_flag !== 1'b1) $display("FAIL sat_neg_flag: got %b exp 1", sat_flag); else pass_cnt++;
      release_result();
   endtask

   task automatic test_relu();
      int lat;
      set_mem(32'h0, 32'h0, 32'h0, 32'h0,
              32'h0001_0000, 32'h0003_0000, 32'hFFFF_0000, 32'h0000_8000);
      run_to_done(32'hFFFE_0000, 1'b1, lat);
      total_cnt++; if (out_data !== 32'h0) $display("FAIL relu_on_out: got %h exp 0", out_data); else pass_cnt++;
      total_cnt++; if (sat_flag !== 1'b0) $display("FAIL relu_on_sat_cleared: got %b exp 0", sat_flag); else pass_cnt++;
      release_result();
      run_to_done(32'hFFFE_0000, 1'b0, lat);
      total_cnt++; if (out_data !== 32'hFFFE_0000) $display("FAIL relu_off_out: got %h exp fffe0000", out_data); else pass_cnt++;
      total_cnt++; if (sat_flag !== 1'b0) $display("FAIL relu_off_sat: got %b exp 0", sat_flag); else pass_cnt++;
      release_result();
   endtask

   task automatic test_stall();
      int lat;
      set_mem(32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 32'hFFFF_0000,
              32'h0000_8000, 32'h0000_4000, 32'h0002_0000, 32'h0001_0000);
      @(negedge clk); start = 1'b1; bias = 32'h0001_0000; relu_en = 1'b0;
      @(negedge clk); start = 1'b0;
      @(negedge clk); start = 1'b1; bias = 32'h0100_0000;
      @(negedge clk); start = 1'b0;
      lat = 2;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      total_cnt++; if (lat !== 6) $display("FAIL stall_latency: got %0d exp 6", lat); else pass_cnt++;
      for (int i = 0; i < 5; i++) begin
         start = (i % 2 == 0);
         total_cnt++; if (out_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %b exp 1", i, out_valid); else pass_cnt++;
         total_cnt++; if (out_data !== 32'h0002_0000) $display("FAIL stall_data[%0d]: got %h exp 00020000", i, out_data); else pass_cnt++;
         @(negedge clk);
      end
      start = 1'b0;
      release_result();
      total_cnt++; if (busy !== 1'b0) $display("FAIL stall_exit_busy: got %b exp 0", busy); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (busy !== 1'b0) $display("FAIL stall_no_queue: got %b exp 0", busy); else pass_cnt++;
   endtask

   task automatic test_reset_mid_run();
      int lat;
      logic saw_valid;
      @(negedge clk); start = 1'b1; bias = 32'h0001_0000; relu_en = 1'b0;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      total_cnt++; if (rd_addr !== 2'd2) $display("FAIL midrst_addr: got %0d exp 2", rd_addr); else pass_cnt++;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b exp 0", busy); else pass_cnt++;
      total_cnt++; if (rd_en !== 1'b0) $display("FAIL midrst_rd_en: got %b exp 0", rd_en); else pass_cnt++;
      total_cnt++; if (rd_addr !== 2'd0) $display("FAIL midrst_rd_addr: got %0d exp 0", rd_addr); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL midrst_valid: got %b exp 0", out_valid); else pass_cnt++;
      total_cnt++; if (out_data !== 32'h0) $display("FAIL midrst_data: got %h exp 0", out_data); else pass_cnt++;
      saw_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid || busy) saw_valid = 1'b1;
      end
      total_cnt++; if (saw_valid !== 1'b0) $display("FAIL midrst_no_output: got %b exp 0", saw_valid); else pass_cnt++;
      run_to_done(32'h0001_0000, 1'b0, lat);
      total_cnt++; if (lat !== 6) $display("FAIL midrst_rerun_lat: got %0d exp 6", lat); else pass_cnt++;
      total_cnt++; if (out_data !== 32'h0002_0000) $display("FAIL midrst_rerun_out: got %h exp 00020000", out_data); else pass_cnt++;
      release_result();
   endtask

   task automatic test_back_to_back();
      int          accepts[$];
      logic [1:0]  addrs[$];
      logic [31:0] results[$];
      logic        prev_busy;
      prev_busy = 1'b0;
      @(negedge clk); start = 1'b1; bias = 32'h0001_0000; relu_en = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         if (busy && !prev_busy) accepts.push_back(i);
         if (rd_en) addrs.push_back(rd_addr);
         if (out_valid) results.push_back(out_data);
         prev_busy = busy;
      end
      start = 1'b0;
      repeat (2) @(negedge clk);
      out_ready = 1'b0;
      total_cnt++; if (accepts.size() !== 4) $display("FAIL b2b_accepts: got %0d exp 4", accepts.size()); else pass_cnt++;
      for (int i = 1; i < accepts.size(); i++) begin
         total_cnt++;
         if (accepts[i] - accepts[i-1] !== N + 4) $display("FAIL b2b_spacing[%0d]: got %0d exp %0d", i, accepts[i] - accepts[i-1], N + 4);
         else pass_cnt++;
      end
      total_cnt++; if (addrs.size() !== 16) $display("FAIL b2b_addr_count: got %0d exp 16", addrs.size()); else pass_cnt++;
      for (int i = 0; i < addrs.size(); i++) begin
         total_cnt++;
         if (addrs[i] !== 2'(i % N)) $display("FAIL b2b_addr[%0d]: got %0d exp %0d", i, addrs[i], i % N);
         else pass_cnt++;
      end
      total_cnt++; if (results.size() !== 4) $display("FAIL b2b_result_count: got %0d exp 4", results.size()); else pass_cnt++;
      for (int i = 0; i < results.size(); i++) begin
         total_cnt++;
         if (results[i] !== 32'h0002_0000) $display("FAIL b2b_result[%0d]: got %h exp 00020000", i, results[i]);
         else pass_cnt++;
      end
   endtask

   initial begin
      set_mem(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      test_reset();
      test_basic();
      test_saturation();
      test_relu();
      test_stall();
      test_reset_mid_run();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
